// File: rtl/syn_cir_adder.sv
// syn_cir_adder: two-stage pipelined four-operand adder with carry-in and overflow flag
module syn_cir_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk1,
  input  logic             clk2,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             cin,
  input  logic             rst,
  output logic             cout,
  output logic [WIDTH-1:0] sum
);
  logic [WIDTH:0]   p1, p2;
  logic [WIDTH+1:0] total;
  logic             unused_clk2;
  assign unused_clk2 = clk2;
  assign total = (WIDTH+2)'(p1) + (WIDTH+2)'(p2);
  always_ff @(posedge clk1 or negedge rst)
    if (!rst) begin
      p1   <= '0;
      p2   <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      p1   <= (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
      p2   <= (WIDTH+1)'(c) + (WIDTH+1)'(d);
      sum  <= total[WIDTH-1:0];
      cout <= |total[WIDTH+1:WIDTH];
    end
endmodule

// File: tb/tb_syn_cir_adder.sv
// tb_syn_cir_adder: scoreboard bench for the pipelined four-operand adder
module tb_syn_cir_adder;
  logic       clk1 = 1'b0, clk2 = 1'b0, rst;
  logic [7:0] a, b, c, d, sum;
  logic       cin, cout;
  logic       clk2_toggle = 1'b0, clk2_level = 1'b0;
  logic [8:0] q[$];
  logic [8:0] e;
  int         checks = 0, errors = 0;

  syn_cir_adder #(.WIDTH(8)) dut (
    .clk1(clk1), .clk2(clk2), .a(a), .b(b), .c(c), .d(d),
    .cin(cin), .rst(rst), .cout(cout), .sum(sum)
  );

  always #5 clk1 = ~clk1;
  initial forever begin
    #3;
    clk2 = clk2_toggle ? ~clk2 : clk2_level;
  end

  task automatic drive(input logic [7:0] va, vb, vc, vd, input logic vcin);
    int t;
    a = va; b = vb; c = vc; d = vd; cin = vcin;
    t = int'(va) + int'(vb) + int'(vc) + int'(vd) + int'(vcin);
    q.push_back({1'(t > 255), t[7:0]});
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(8'hff, 8'hff, 8'hff, 8'hff, 1'b1);
    #1;
    checks++;
    if ({cout, sum} !== 9'h0) begin
      errors++;
      $display("FAIL reset_immediate: got cout=%0b sum=%0d expected cout=0 sum=0", cout, sum);
    end
    repeat (3) @(posedge clk1);
    #1;
    checks++;
    if ({cout, sum} !== 9'h0) begin
      errors++;
      $display("FAIL reset_held: got cout=%0b sum=%0d expected cout=0 sum=0", cout, sum);
    end
    @(negedge clk1);
    rst = 1'b1;
    q.delete();
    q.push_back(9'h0);
    drive(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
  endtask

  task automatic test_basic;
    repeat (3) begin
      @(negedge clk1);
      if (q.size() == 2) begin
        e = q.pop_front(); checks++;
        if ({cout, sum} !== e) begin
          errors++;
          $display("FAIL basic: got cout=%0b sum=%0d expected cout=%0b sum=%0d", cout, sum, e[8], e[7:0]);
        end
      end
      drive(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    end
  endtask

  task automatic test_operand_change;
    repeat (3) begin
      @(negedge clk1);
      if (q.size() == 2) begin
        e = q.pop_front(); checks++;
        if ({cout, sum} !== e) begin
          errors++;
          $display("FAIL operand_change: got cout=%0b sum=%0d expected cout=%0b sum=%0d", cout, sum, e[8], e[7:0]);
        end
      end
      drive(8'd1, 8'd1, 8'd3, 8'd4, 1'b0);
    end
  endtask

  task automatic test_boundary;
    logic [32:0] vec[7] = '{
      {8'd100, 8'd100, 8'd50, 8'd6, 1'b0},
      {8'd255, 8'd255, 8'd255, 8'd255, 1'b1},
      {8'd255, 8'd0, 8'd0, 8'd0, 1'b0},
      {8'd255, 8'd0, 8'd0, 8'd0, 1'b1},
      {8'd0, 8'd0, 8'd0, 8'd0, 1'b0},
      {8'd0, 8'd0, 8'd0, 8'd0, 1'b1},
      {8'd128, 8'd0, 8'd127, 8'd0, 1'b0}
    };
    foreach (vec[i]) begin
      @(negedge clk1);
      if (q.size() == 2) begin
        e = q.pop_front(); checks++;
        if ({cout, sum} !== e) begin
          errors++;
          $display("FAIL boundary: got cout=%0b sum=%0d expected cout=%0b sum=%0d", cout, sum, e[8], e[7:0]);
        end
      end
      drive(vec[i][32:25], vec[i][24:17], vec[i][16:9], vec[i][8:1], vec[i][0]);
    end
  endtask

  task automatic test_glitch;
    repeat (4) begin
      @(negedge clk1);
      if (q.size() == 2) begin
        e = q.pop_front(); checks++;
        if ({cout, sum} !== e) begin
          errors++;
          $display("FAIL glitch: got cout=%0b sum=%0d expected cout=%0b sum=%0d", cout, sum, e[8], e[7:0]);
        end
      end
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom); cin = 1'($urandom);
      #2;
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back(input int n);
    repeat (n) begin
      @(negedge clk1);
      if (q.size() == 2) begin
        e = q.pop_front(); checks++;
        if ({cout, sum} !== e) begin
          errors++;
          $display("FAIL back_to_back: got cout=%0b sum=%0d expected cout=%0b sum=%0d", cout, sum, e[8], e[7:0]);
        end
      end
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_mid_reset;
    drive(8'd200, 8'd200, 8'd200, 8'd200, 1'b1);
    @(posedge clk1);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({cout, sum} !== 9'h0) begin
      errors++;
      $display("FAIL mid_reset: got cout=%0b sum=%0d expected cout=0 sum=0", cout, sum);
    end
    @(posedge clk1);
    #1;
    checks++;
    if ({cout, sum} !== 9'h0) begin
      errors++;
      $display("FAIL mid_reset_hold: got cout=%0b sum=%0d expected cout=0 sum=0", cout, sum);
    end
    @(negedge clk1);
    rst = 1'b1;
    q.delete();
    q.push_back(9'h0);
    drive(8'd9, 8'd8, 8'd7, 8'd6, 1'b1);
    repeat (4) begin
      @(negedge clk1);
      if (q.size() == 2) begin
        e = q.pop_front(); checks++;
        if ({cout, sum} !== e) begin
          errors++;
          $display("FAIL recovery: got cout=%0b sum=%0d expected cout=%0b sum=%0d", cout, sum, e[8], e[7:0]);
        end
      end
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_clk2;
    for (int m = 0; m < 3; m++) begin
      clk2_toggle = (m == 0);
      clk2_level  = (m == 1);
      repeat (10) begin
        @(negedge clk1);
        if (q.size() == 2) begin
          e = q.pop_front(); checks++;
          if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL clk2_mode%0d: got cout=%0b sum=%0d expected cout=%0b sum=%0d", m, cout, sum, e[8], e[7:0]);
          end
        end
        drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      end
    end
  endtask

  task automatic test_flush;
    while (q.size() > 0) begin
      @(negedge clk1);
      e = q.pop_front(); checks++;
      if ({cout, sum} !== e) begin
        errors++;
        $display("FAIL flush: got cout=%0b sum=%0d expected cout=%0b sum=%0d", cout, sum, e[8], e[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_operand_change();
    test_boundary();
    test_glitch();
    test_back_to_back(40);
    test_mid_reset();
    test_clk2();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/syn_cir_adder.md
SYN_CIR_ADDER -- requirements
Module: syn_cir

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Positional port order SHALL be: clk1, clk2, a, b, c, d, cin, rst, cout, sum.
REQ-004 clk1  input  1  sole clock; all registers update on the rising edge.
REQ-005 rst  input  1  asynchronous reset, active low.
REQ-006 clk2  input  1  reserved for port compatibility; it SHALL be ignored (no logic, no clocking).
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 c  input  WIDTH  operand C.
REQ-010 d  input  WIDTH  operand D.
REQ-011 cin  input  1  carry-in, added once into the total.
REQ-012 cout  output  1  overflow flag: total does not fit in WIDTH bits.
REQ-013 sum  output  WIDTH  total modulo 2^WIDTH.
REQ-014 Both outputs SHALL be driven directly from registers (no combinational input-to-output path).

Function
REQ-015 Total is defined as T = a + b + c + d + cin, computed unsigned at full precision (max 4*(2^WIDTH-1)+1).
REQ-016 The datapath SHALL be a 2-stage pipeline clocked by clk1.
REQ-017 Stage 1: on each rising edge, register P1 = a + b + cin (WIDTH+1 bits) and P2 = c + d (WIDTH+1 bits).
REQ-018 Stage 2: on each rising edge, register sum = (P1 + P2) mod 2^WIDTH.
REQ-019 Stage 2: on the same edge, register cout = 1 if P1 + P2 >= 2^WIDTH, else 0.
REQ-020 Latency: inputs sampled at rising edge N SHALL appear on sum/cout after rising edge N+1; outputs are stable until edge N+2.
REQ-021 Throughput: one new operand set accepted every clk1 cycle, with no stalls and no handshake.
REQ-022 Wrap-around: sum SHALL wrap modulo 2^WIDTH; cout SHALL NOT count how many times it wrapped.
REQ-023 Input changes between clock edges SHALL have no effect until the next rising edge.

Reset
REQ-024 While rst = 0, P1, P2, sum and cout SHALL be 0 immediately, independent of clk1.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight pipeline data.
REQ-026 After rst rises, the first valid result SHALL appear after the second rising edge of clk1.
REQ-027 Until that second edge, outputs SHALL read 0.
REQ-028 Without any reset pulse, outputs are undefined until two edges after defined inputs; this SHALL be accepted.

Verification
REQ-029 Basic sum: rst=1, a=1, b=2, c=3, d=4, cin=0 held → after 2 edges, sum=10, cout=0.
REQ-030 Operand change: a=1, b=1 with c=3, d=4, cin=0 → sum=9 two edges later; sum=10 persists for exactly 1 cycle in between.
REQ-031 Exact overflow: a=100, b=100, c=50, d=6, cin=0 → sum=0, cout=1.
REQ-032 Maximum total: a=b=c=d=255, cin=1 (T=1021) → sum=0xFD, cout=1.
REQ-033 Mid-operation reset: rst pulled low between edges while busy → sum=0, cout=0 at once.
REQ-034 Recovery after reset: after rst rises, outputs stay 0 through the first edge; correct result appears on the second edge.
REQ-035 Streaming: a new operand set each cycle → each result appears exactly 2 edges after its inputs.
REQ-036 clk2 independence: clk2 toggled or held at any level → no change in behaviour.
